param_bank_write_arbiter: RTL and testbench



---
 rtl/param_bank_pkg.sv | 24 ++
 rtl/param_bank_write_arbiter_if.sv | 38 +++
 rtl/param_bank_write_arbiter_rr_arbiter.sv | 29 ++
 rtl/param_bank_write_arbiter.sv | 120 ++++++++++++
 tb/tb_param_bank_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_bank_pkg.sv
// Shared types and constants for the parameter-bank write arbiter and its register bank.
package param_bank_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Bits needed to index n entries, never less than one.
  function automatic int addr_w_f(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/param_bank_write_arbiter_if.sv
// Requester-side bus of the parameter-bank write arbiter. The lock vector exists only
// when ARB_LOCK_EN is defined.
interface param_bank_write_arbiter_if
  import param_bank_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
);
  localparam int ADDR_W = addr_w_f(NUM_REGS);

  // Handshake: requester k raises req[k] with addr/data and holds it until ack[k]
  // pulses for one cycle; in the cycle after ack it must drop req or present a new write.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [NUM_REGS-1:0]       load;
  logic [DATA_W-1:0]         wdata;

`ifdef ARB_LOCK_EN
  logic [NUM_REQ-1:0]        lock;

  modport master (output req, addr, data, lock,
                  input  ack, err, grant, busy, load, wdata);
  modport slave  (input  req, addr, data, lock,
                  output ack, err, grant, busy, load, wdata);
`else
  modport master (output req, addr, data,
                  input  ack, err, grant, busy, load, wdata);
  modport slave  (input  req, addr, data,
                  output ack, err, grant, busy, load, wdata);
`endif

endinterface

// File: rtl/param_bank_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        found = 1'b1;
        gnt_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/param_bank_write_arbiter.sv
// Round-robin write arbiter for a bank of load-enabled parameter registers.
// Define ARB_LOCK_EN to add per-requester lock for burst writes.
module param_bank_write_arbiter
  import param_bank_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  param_bank_write_arbiter_if.slave   bus,
  output state_e                      state_o
);

  localparam int ADDR_W = addr_w_f(NUM_REGS);
  localparam int IDX_W  = addr_w_f(NUM_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [NUM_REQ-1:0]  win_oh_q, win_oh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                err_pend;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // An address past the last register completes normally but flags err instead of loading.
  assign err_pend = (int'(addr_q) >= NUM_REGS);
  assign state_o  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      win_oh_q <= win_oh_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    win_oh_d = win_oh_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = LOAD;
          win_d    = pick_idx;
          win_oh_d = pick_gnt;
          addr_d   = bus.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          data_d   = bus.data[int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      LOAD: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`ifdef ARB_LOCK_EN
        // A locked winner keeps top priority so a burst is not interleaved.
        if (bus.lock[win_q]) ptr_d = win_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ack   = '0;
    bus.err   = 1'b0;
    bus.grant = '0;
    bus.busy  = 1'b0;
    bus.load  = '0;
    bus.wdata = '0;
    case (state_q)
      LOAD: begin
        bus.busy  = 1'b1;
        bus.grant = win_oh_q;
        bus.wdata = data_q;
        for (int r = 0; r < NUM_REGS; r++) begin
          bus.load[r] = !err_pend && (addr_q == ADDR_W'(r));
        end
      end
      ACK: begin
        bus.busy  = 1'b1;
        bus.grant = win_oh_q;
        bus.ack   = win_oh_q;
        bus.err   = err_pend;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_param_bank_write_arbiter.sv
// Randomized scoreboard bench for param_bank_write_arbiter with a six-register bank.
module tb_param_bank_write_arbiter;
  import param_bank_pkg::*;

  localparam int NR = 4;
  localparam int NG = 6;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_v;
  always #5 clk = ~clk;

  logic [NR-1:0] req_v;
  logic [NR-1:0] lock_v;
  logic [AW-1:0] addr_v [NR];
  logic [DW-1:0] data_v [NR];
  state_e        dbg_state;

  param_bank_write_arbiter_if #(.NUM_REQ(NR), .NUM_REGS(NG), .DATA_W(DW)) bus ();

  param_bank_write_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset   (reset_v),
    .bus     (bus),
    .state_o (dbg_state)
  );

  assign bus.req = req_v;
  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign bus.addr[k*AW +: AW] = addr_v[k];
    assign bus.data[k*DW +: DW] = data_v[k];
  end
`ifdef ARB_LOCK_EN
  assign bus.lock = lock_v;
`endif

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [45:0] exp_load_q [$];   // {cycle, load vector, wdata}
  logic [47:0] exp_ack_q  [$];   // {cycle, ack vector, err, addr, data}

  logic [DW-1:0] ref_bank [NG];
  logic [DW-1:0] obs_bank [NG];
  logic [NR-1:0] ack_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A write occupies the arbiter for three cycles; the winner is the first requester
  // at or after the priority pointer, and the pointer moves past the winner when done.
  int            ptr, busy_left, cur_w, w, a;
  logic [DW-1:0] d;
  bit            oor;
  logic [NG-1:0] ld;

  always @(posedge clk) begin
    cyc++;
    if (reset_v) begin
      ptr = 0;
      busy_left = 0;
      exp_ack_q.delete();
    end else if (busy_left == 2) begin
      busy_left = 1;
    end else if (busy_left == 1) begin
      ptr = (LOCK_EN && lock_v[cur_w]) ? cur_w : (cur_w + 1) % NR;
      busy_left = 0;
    end else if (req_v != '0) begin
      w = -1;
      for (int i = 0; i < NR; i++) begin
        if (w < 0 && req_v[(ptr + i) % NR]) w = (ptr + i) % NR;
      end
      cur_w = w;
      busy_left = 2;
      a = int'(addr_v[w]);
      d = data_v[w];
      oor = (a >= NG);
      ld = '0;
      if (!oor) begin
        ld[a] = 1'b1;
        ref_bank[a] = d;
        exp_load_q.push_back({32'(cyc), ld, d});
      end
      exp_ack_q.push_back({32'(cyc + 1), NR'(1) << w, oor, AW'(a), d});
    end
  end

  // ---------------- monitor ----------------
  logic [45:0]   le;
  logic [47:0]   ae;
  state_e        exp_state;

  always @(negedge clk) begin
    ack_seen = bus.ack;
    if (cyc >= 1) begin
      exp_state = (busy_left == 2) ? LOAD : (busy_left == 1) ? ACK : IDLE;
      check("busy", bus.busy, busy_left != 0);
      check("state", dbg_state, exp_state);
      check("grant", bus.grant, (busy_left != 0) ? (NR'(1) << cur_w) : NR'(0));
      check("load_onehot", $countones(bus.load) <= 1, 1);
      check("load_ack_excl", (bus.load != '0) && (bus.ack != '0), 0);

      while (exp_load_q.size() > 0 && int'(exp_load_q[0][45:14]) < cyc) begin
        check("load_missing", exp_load_q[0][45:14], cyc);
        void'(exp_load_q.pop_front());
      end
      while (exp_ack_q.size() > 0 && int'(exp_ack_q[0][47:16]) < cyc) begin
        check("ack_missing", exp_ack_q[0][47:16], cyc);
        void'(exp_ack_q.pop_front());
      end

      if (bus.load != '0) begin
        for (int r = 0; r < NG; r++) if (bus.load[r]) obs_bank[r] = bus.wdata;
        if (exp_load_q.size() == 0) begin
          check("load_unexpected", bus.load, 0);
        end else begin
          le = exp_load_q.pop_front();
          check("load_cycle", cyc, le[45:14]);
          check("load_vec", bus.load, le[13:8]);
          check("wdata", bus.wdata, le[7:0]);
        end
      end

      if (bus.ack != '0) begin
        if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", bus.ack, 0);
        end else begin
          ae = exp_ack_q.pop_front();
          check("ack_cycle", cyc, ae[47:16]);
          check("ack_vec", bus.ack, ae[15:12]);
          check("err", bus.err, ae[11]);
          if (!ae[11]) check("bank_after_write", obs_bank[ae[10:8]], ae[7:0]);
        end
      end else begin
        check("err_idle", bus.err, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic one_txn(input int k, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    addr_v[k] = ad;
    data_v[k] = dt;
    req_v[k]  = 1'b1;
    repeat (3) step();
    req_v[k]  = 1'b0;
    step();
  endtask

  task automatic new_req(input int k);
    req_v[k]  = 1'b1;
    addr_v[k] = AW'($urandom_range(0, 7));
    data_v[k] = DW'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_v = 1'b1;
    req_v   = '0;
    lock_v  = '0;
    for (int k = 0; k < NR; k++) begin
      addr_v[k] = '0;
      data_v[k] = '0;
    end
    for (int r = 0; r < NG; r++) begin
      ref_bank[r] = '0;
      obs_bank[r] = '0;
    end
    repeat (3) step();
    reset_v = 1'b0;
    step();

    // Single write from requester 1.
    one_txn(1, 3'd3, 8'hA5);

    // Fresh pointer, all four requesters held continuously.
    reset_v = 1'b1;
    step();
    reset_v = 1'b0;
    addr_v[0] = 3'd1; data_v[0] = 8'h10;
    addr_v[1] = 3'd2; data_v[1] = 8'h21;
    addr_v[2] = 3'd4; data_v[2] = 8'h42;
    addr_v[3] = 3'd5; data_v[3] = 8'h53;
    req_v = 4'b1111;
    repeat (15) step();
    req_v = '0;
    step();

    // Data changed during LOAD and req dropped during ACK.
    addr_v[0] = 3'd5; data_v[0] = 8'h3C; req_v[0] = 1'b1;
    step();
    data_v[0] = 8'hFF;
    step();
    req_v[0] = 1'b0;
    repeat (2) step();

    // Out-of-range address.
    one_txn(2, 3'd7, 8'h77);

    // Reset during LOAD, then all request: requester 0 must win.
    one_txn(0, 3'd1, 8'h11);
    addr_v[2] = 3'd2; data_v[2] = 8'h22; req_v[2] = 1'b1;
    step();
    reset_v = 1'b1;
    req_v = '0;
    step();
    reset_v = 1'b0;
    step();
    for (int k = 0; k < NR; k++) begin
      addr_v[k] = AW'(k); data_v[k] = DW'(8'hC0 + k);
    end
    req_v = 4'b1111;
    repeat (3) step();
    req_v = '0;
    step();

    // Requesters 1 and 3 with lock1 held for the first three writes.
    addr_v[1] = 3'd3; data_v[1] = 8'h31;
    addr_v[3] = 3'd4; data_v[3] = 8'h43;
    req_v = 4'b1010;
    lock_v[1] = 1'b1;
    repeat (8) step();
    lock_v[1] = 1'b0;
    repeat (4) step();
    req_v = '0;
    step();

    // Random traffic.
    for (int t = 0; t < 2000; t++) begin
      step();
      reset_v = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NR; k++) begin
        lock_v[k] = ($urandom_range(0, 3) == 0);
        if (ack_seen[k]) begin
          if ($urandom_range(0, 1) == 1) new_req(k);
          else req_v[k] = 1'b0;
        end else if (!req_v[k]) begin
          if ($urandom_range(0, 4) == 0) new_req(k);
        end else begin
          if ($urandom_range(0, 19) == 0) req_v[k] = 1'b0;
          if ($urandom_range(0, 9) == 0) data_v[k] = DW'($urandom);
        end
      end
    end

    // Drain and final report.
    reset_v = 1'b0;
    req_v   = '0;
    lock_v  = '0;
    repeat (10) step();
    for (int r = 0; r < NG; r++) check($sformatf("bank_reg%0d", r), obs_bank[r], ref_bank[r]);
    check("load_queue_drained", exp_load_q.size(), 0);
    check("ack_queue_drained", exp_ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
